// File: rtl/duty_cycle_meter_if.sv
// Signal-side bundle of the duty cycle meter: enable and input pin toward the
// meter, result registers and status strobes back from it.
`timescale 1ns/1ps
interface duty_cycle_meter_if;
    logic       Enable;
    logic       Signal;
    logic [6:0] DutyPercent;
    logic [3:0] Hundreds;
    logic [3:0] Tens;
    logic [3:0] Ones;
    logic       DutyValid;
    logic       Busy;

    modport master (
        output Enable, Signal,
        input  DutyPercent, Hundreds, Tens, Ones, DutyValid, Busy
    );

    modport slave (
        input  Enable, Signal,
        output DutyPercent, Hundreds, Tens, Ones, DutyValid, Busy
    );
endinterface

// File: rtl/duty_cycle_meter.sv
// Windowed duty cycle meter: samples a synchronised input on prescaled ticks,
// counts high samples over WINDOW ticks, then divides and converts to BCD.
`timescale 1ns/1ps
module duty_cycle_meter #(
    parameter int unsigned PRESCALE = 2500,
    parameter int unsigned WINDOW   = 200
) (
    input logic              InputClock,
    input logic              Reset,
    duty_cycle_meter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WINDOW + 1);
    localparam int unsigned NUM_W = CNT_W + 7;
    localparam int unsigned PS_W  = $clog2(PRESCALE);

    typedef enum logic [1:0] {IDLE, DIVIDE, CONVERT} state_t;

    logic             sync_a;
    logic             sync_b;
    logic [PS_W-1:0]  ps_cnt;
    logic             tick;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] high_final;
    logic             win_close;
    logic [NUM_W-1:0] num_load;

    state_t           state;
    logic [NUM_W-1:0] rem;
    logic [NUM_W-1:0] dsh;
    logic [6:0]       quo;
    logic [2:0]       step;

    logic             hund_c;
    logic [6:0]       q_lo;
    logic [3:0]       tens_c;
    logic [3:0]       ones_c;

    assign tick       = bus.Enable && (ps_cnt == PS_W'(PRESCALE - 1));
    assign win_close  = tick && (smp_cnt == CNT_W'(WINDOW - 1));
    assign high_final = high_cnt + CNT_W'(sync_b);
    assign num_load   = NUM_W'(high_final) * NUM_W'(7'd100);

    // Two-flop synchroniser for the asynchronous input pin
    always_ff @(posedge InputClock) begin
        if (Reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= bus.Signal;
            sync_b <= sync_a;
        end
    end

    // Prescaler: one-cycle tick every PRESCALE cycles while enabled
    always_ff @(posedge InputClock) begin
        if (Reset || !bus.Enable) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    // Window counters; a closing tick restarts both so no sample is lost
    always_ff @(posedge InputClock) begin
        if (Reset || !bus.Enable) begin
            smp_cnt  <= '0;
            high_cnt <= '0;
        end else if (win_close) begin
            smp_cnt  <= '0;
            high_cnt <= '0;
        end else if (tick) begin
            smp_cnt  <= smp_cnt + CNT_W'(1);
            high_cnt <= high_final;
        end
    end

    // Binary to BCD of the 0..100 quotient
    always_comb begin
        hund_c = (quo == 7'd100);
        q_lo   = hund_c ? 7'd0 : quo;
        tens_c = '0;
        for (int unsigned i = 1; i < 10; i++) begin
            if (q_lo >= 7'(i * 10)) tens_c = 4'(i);
        end
        ones_c = 4'(q_lo - 7'(32'(tens_c) * 10));
    end

    // Control FSM: latch numerator, 7-step restoring divide, convert, publish.
    // The divisor starts at WINDOW<<6 and shifts right, so the numerator is
    // never shifted and each step decides one quotient bit MSB first.
    always_ff @(posedge InputClock) begin
        if (Reset) begin
            state           <= IDLE;
            rem             <= '0;
            dsh             <= '0;
            quo             <= '0;
            step            <= '0;
            bus.DutyPercent <= '0;
            bus.Hundreds    <= '0;
            bus.Tens        <= '0;
            bus.Ones        <= '0;
            bus.DutyValid   <= 1'b0;
            bus.Busy        <= 1'b0;
        end else begin
            bus.DutyValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_close) begin
                        rem      <= num_load;
                        dsh      <= NUM_W'(WINDOW) << 6;
                        quo      <= '0;
                        step     <= '0;
                        bus.Busy <= 1'b1;
                        state    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (rem >= dsh) rem <= rem - dsh;
                    quo  <= {quo[5:0], (rem >= dsh)};
                    dsh  <= dsh >> 1;
                    step <= step + 3'd1;
                    if (step == 3'd6) state <= CONVERT;
                end
                CONVERT: begin
                    bus.DutyPercent <= quo;
                    bus.Hundreds    <= {3'b000, hund_c};
                    bus.Tens        <= tens_c;
                    bus.Ones        <= ones_c;
                    bus.DutyValid   <= 1'b1;
                    bus.Busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_duty_cycle_meter.sv
// Directed bench for duty_cycle_meter: three instances (PRESCALE=16, WINDOW
// 10/8/3) share clock and reset; one is selected per test. Cycle n is sampled
// at the falling edge just before rising edge n; edge 0 is the last rising
// edge with Reset high. Inputs change 1 ns after a rising edge.
`timescale 1ns/1ps
module tb_duty_cycle_meter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en;
    int   drv;
    int   kk;
    int   sel;
    int   off_lo;
    int   off_hi;
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    int   e_pct, e_h, e_t, e_o;

    // High for the first k ticks of each w-tick window; transitions sit midway
    // between ticks so the 2-flop synchroniser delay is absorbed.
    function automatic logic pat(int d, int w, int k);
        int n;
        n = (d + 8) / 16;
        return ((n + w - 1) % w) < k;
    endfunction

    duty_cycle_meter_if if10();
    duty_cycle_meter_if if8();
    duty_cycle_meter_if if3();

    assign if10.Enable = en;
    assign if8.Enable  = en;
    assign if3.Enable  = en;
    assign if10.Signal = pat(drv, 10, kk);
    assign if8.Signal  = pat(drv, 8, kk);
    assign if3.Signal  = pat(drv, 3, kk);

    duty_cycle_meter #(.PRESCALE(16), .WINDOW(10)) dut10 (.InputClock(clk), .Reset(rst), .bus(if10));
    duty_cycle_meter #(.PRESCALE(16), .WINDOW(8))  dut8  (.InputClock(clk), .Reset(rst), .bus(if8));
    duty_cycle_meter #(.PRESCALE(16), .WINDOW(3))  dut3  (.InputClock(clk), .Reset(rst), .bus(if3));

    logic [6:0] m_pct;
    logic [3:0] m_h, m_t, m_o;
    logic       m_v, m_b;

    always_comb begin
        m_pct = if10.DutyPercent; m_h = if10.Hundreds; m_t = if10.Tens;
        m_o = if10.Ones; m_v = if10.DutyValid; m_b = if10.Busy;
        if (sel == 1) begin
            m_pct = if8.DutyPercent; m_h = if8.Hundreds; m_t = if8.Tens;
            m_o = if8.Ones; m_v = if8.DutyValid; m_b = if8.Busy;
        end else if (sel == 2) begin
            m_pct = if3.DutyPercent; m_h = if3.Hundreds; m_t = if3.Tens;
            m_o = if3.Ones; m_v = if3.DutyValid; m_b = if3.Busy;
        end
    end

    typedef struct {
        int sel;
        int k;
        int pct;
        int h;
        int t;
        int o;
    } vec_t;

    vec_t vecs[10];

    function automatic int win_of(int s);
        return (s == 0) ? 10 : (s == 1) ? 8 : 3;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s sel=%0d cycle=%0d actual=%0d required=%0d", name, sel, cyc, act, exp);
        end
    endtask

    // Move from the sampling point of cycle cyc to that of cyc+1
    task automatic advance();
        @(posedge clk);
        #1;
        drv = cyc;
        en  = !(drv >= off_lo && drv < off_hi);
        @(negedge clk);
        cyc++;
    endtask

    // Called at a sampling point; leaves the bench at the sampling point of cycle 1
    task automatic do_reset();
        rst = 1'b1;
        drv = 0;
        en  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        cyc = 1;
    endtask

    task automatic chk_reset_state();
        chk("rst_pct",   int'(m_pct), 0);
        chk("rst_hund",  int'(m_h),   0);
        chk("rst_tens",  int'(m_t),   0);
        chk("rst_ones",  int'(m_o),   0);
        chk("rst_valid", int'(m_v),   0);
        chk("rst_busy",  int'(m_b),   0);
    endtask

    // Runs to cycle 'last'; DutyValid must be high exactly on s1/s2, Busy on
    // the eight cycles before each, results must match at each strobe and hold.
    task automatic run_check(input int last, input int s1, input int s2);
        int   bad_v;
        int   bad_b;
        logic exp_v;
        logic exp_b;
        bad_v = 0;
        bad_b = 0;
        forever begin
            exp_v = (cyc == s1) || (cyc == s2);
            exp_b = (cyc >= s1 - 8 && cyc <= s1 - 1) || (cyc >= s2 - 8 && cyc <= s2 - 1);
            if (m_v !== exp_v) bad_v++;
            if (m_b !== exp_b) bad_b++;
            if (cyc == s1 || cyc == s2) begin
                chk("pct",  int'(m_pct), e_pct);
                chk("hund", int'(m_h),   e_h);
                chk("tens", int'(m_t),   e_t);
                chk("ones", int'(m_o),   e_o);
            end
            if (cyc == s1 + 10) chk("pct_hold", int'(m_pct), e_pct);
            if (cyc >= last) break;
            advance();
        end
        chk("valid_timing_bad_cycles", bad_v, 0);
        chk("busy_timing_bad_cycles",  bad_b, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; en = 1'b1; drv = 0; kk = 0; sel = 0;
        off_lo = 0; off_hi = 0; cyc = 0;

        //           sel  k   pct h  t  o
        vecs[0] = '{0, 10, 100, 1, 0, 0};
        vecs[1] = '{0,  0,   0, 0, 0, 0};
        vecs[2] = '{0,  5,  50, 0, 5, 0};
        vecs[3] = '{0,  3,  30, 0, 3, 0};
        vecs[4] = '{1,  2,  25, 0, 2, 5};
        vecs[5] = '{1,  7,  87, 0, 8, 7};
        vecs[6] = '{1,  1,  12, 0, 1, 2};
        vecs[7] = '{2,  1,  33, 0, 3, 3};
        vecs[8] = '{2,  2,  66, 0, 6, 6};
        vecs[9] = '{2,  3, 100, 1, 0, 0};

        @(negedge clk);
        foreach (vecs[i]) begin
            sel = vecs[i].sel; kk = vecs[i].k;
            e_pct = vecs[i].pct; e_h = vecs[i].h; e_t = vecs[i].t; e_o = vecs[i].o;
            w = win_of(sel);
            do_reset();
            chk_reset_state();
            run_check(32 * w + 11, 16 * w + 9, 32 * w + 9);
        end

        // Reset during the second window's divide aborts it; a fresh
        // measurement then strobes 169 cycles after release.
        sel = 0; kk = 10; e_pct = 100; e_h = 1; e_t = 0; e_o = 0;
        do_reset();
        run_check(320, 169, -1);
        repeat (3) advance();
        chk("busy_in_divide", int'(m_b), 1);
        advance();
        do_reset();
        chk_reset_state();
        run_check(180, 169, -1);

        // Enable low on edges 100..119, raised just after edge 119: the
        // partial window is dropped and the strobe lands at 119+16*10+9.
        do_reset();
        off_lo = 99; off_hi = 119;
        run_check(300, 288, -1);
        off_lo = 0; off_hi = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/duty_cycle_meter.md
Name: duty_cycle_meter

Overview:
- Measures the duty cycle of one asynchronous input over a fixed window of prescaled sample ticks.
- Produces a 0–100 integer percentage plus three BCD digits, with a one-cycle valid strobe per completed window.
- Runs entirely on InputClock using a tick enable, with no derived clock.
- Sits between the raw signal pin and the existing seven-segment decoders.
- Replaces the free-running high/low counters and combinational divide with windowed measurement and a sequential divider.

Parameters:
- PRESCALE, 2500: InputClock cycles per sample tick. Legal range ≥16.
- WINDOW, 200: sample ticks per measurement. Legal range 1..65535.
- CNT_W: localparam, clog2(WINDOW+1). Width of the sample and high counters.

Ports:
- InputClock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  measurement enable.
- Signal  in  1  asynchronous signal under test.
- DutyPercent  out  7  last result, 0..100.
- Hundreds  out  4  BCD hundreds digit, 0 or 1.
- Tens  out  4  BCD tens digit.
- Ones  out  4  BCD ones digit.
- DutyValid  out  1  one-cycle strobe when a new result is loaded.
- Busy  out  1  high while the divide/convert is in progress.

Behaviour:
- Reset (synchronous, active-high, on InputClock):
  - Clears the prescaler, sample counter, high counter, synchroniser and FSM (FSM to IDLE).
  - DutyPercent=0, Hundreds=Tens=Ones=0, DutyValid=0, Busy=0.
- Synchroniser: Signal passes through a 2-FF synchroniser. Only the synchronised value (sync) is sampled.
- Prescaler:
  - Counts 0..PRESCALE-1 while Enable=1.
  - tick=1 for exactly one cycle when count==PRESCALE-1; the count then wraps to 0.
  - The first tick after reset release falls on cycle PRESCALE (first cycle after release = cycle 1).
- Sampling on each tick:
  - The sample counter increments.
  - The high counter increments if sync=1.
- Window close, on the tick that takes the sample counter to WINDOW:
  - The final high count (including this sample) is latched into the divider.
  - Both counters restart at 0 on the same edge, so the next window begins with the next tick and no samples are lost.
- Enable=0:
  - The prescaler and both counters are held at 0 and the partial window is discarded.
  - A divide already in progress completes normally and the result registers hold.
  - On the rising edge of Enable, a fresh window starts and the first tick comes PRESCALE cycles later.
- FSM states: IDLE, DIVIDE, CONVERT.
  - IDLE: on window close, go to DIVIDE. Load numerator = high*100 and divisor = WINDOW.
  - DIVIDE: restoring divider, one quotient bit per cycle, MSB first, 7 cycles, 7-bit quotient. Result = floor(high*100/WINDOW). Then go to CONVERT.
  - CONVERT: one cycle.
    - Hundreds = (q==100).
    - Tens = (q mod 100)/10.
    - Ones = q mod 10.
    - DutyPercent = q.
    - Go to IDLE.
- Outputs and latency:
  - Result registers and DutyValid update together on the cycle after CONVERT.
  - If window close is on cycle T, DutyValid=1 on exactly cycle T+9 and 0 otherwise.
  - Outputs hold their value until the next strobe.
  - Busy=1 from T+1 to T+8 inclusive.
- Overlap: PRESCALE≥16 guarantees the divide completes before the next possible window close. A window close seen while not in IDLE cannot occur in a legal configuration.
- Width rules:
  - The high count never exceeds WINDOW, so the quotient is ≤100 and there is no saturation logic.
  - The numerator is CNT_W+7 bits.
- Reset mid-operation: the divide is aborted, no DutyValid is produced, and all outputs return to their reset values.

Test Plan:
- PRESCALE=16, WINDOW=10, Signal held 1 from reset: ticks on cycles 16,32,…,160 → DutyValid only on cycle 169 with DutyPercent=100 and H/T/O=1/0/0. Busy is high for cycles 161–168.
- Same config, Signal held 0: DutyPercent=0 and digits 0/0/0 on cycle 169. The second DutyValid comes exactly 160 cycles later, on cycle 329.
- PRESCALE=16, WINDOW=8, Signal high for 2 of every 8 ticks (aligned to ticks, accounting for the 2-cycle synchroniser delay) → DutyPercent=25, digits 0/2/5, repeated every window.
- PRESCALE=16, WINDOW=3, 1 high sample per window → DutyPercent=33 (truncation), digits 0/3/3.
- Reset pulsed during DIVIDE, e.g. cycle 164 in scenario 1 → no strobe at 169, outputs 0. The measurement restarts and gives DutyValid 169 cycles after reset release.
- Enable dropped for 20 cycles mid-window, then raised → the partial window is discarded. The next DutyValid comes exactly PRESCALE*WINDOW+9 cycles after the cycle on which Enable rose.
